// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard unit: result-source codes, forwarding
// selects and the MUL/DIV hold FSM state type.
package hazard_pkg;

   localparam logic [1:0] RES_ALU  = 2'b00;
   localparam logic [1:0] RES_LOAD = 2'b01;
   localparam logic [1:0] RES_PC4  = 2'b10;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic {StIdle, StHold} hold_state_e;

   // MEM stage is younger than WB, so it wins when both match.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                          input logic [4:0] rd_w, input logic we_m,
                                          input logic we_w);
      if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
         return FWD_MEM;
      end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
         return FWD_WB;
      end
      return FWD_REG;
   endfunction

endpackage

// File: rtl/muldiv_hold_fsm.sv
// Holds a multi-cycle MUL/DIV op in EX: Busy stays high for MULDIV_LAT-1 cycles,
// then the op leaves EX on the edge where the counter has drained.
module muldiv_hold_fsm
   import hazard_pkg::*;
#(
   parameter int unsigned MULDIV_LAT = 4
) (
   input  logic Clk,
   input  logic Reset,
   input  logic muldiv_i,
   output logic busy_o
);

   localparam int unsigned CntW    = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
   localparam int unsigned InitVal = (MULDIV_LAT > 1) ? MULDIV_LAT - 2 : 0;
   localparam logic [CntW-1:0] CntInit = CntW'(InitVal);
   localparam bit HoldEn = (MULDIV_LAT > 1);

   hold_state_e     state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            busy;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (muldiv_i && HoldEn) begin
               state_d = StHold;
               cnt_d   = CntInit;
               busy    = 1'b1;
            end
         end
         StHold: begin
            // muldiv_i is ignored here so a held op cannot retrigger itself.
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
               busy  = 1'b1;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign busy_o = busy && !Reset;

endmodule

// File: rtl/hazard_unit.sv
// 5-stage pipeline hazard control: operand forwarding, load-use stall, branch flush,
// MUL/DIV hold, plus saturating stall/flush performance counters.
module hazard_unit
   import hazard_pkg::*;
#(
   parameter int unsigned MULDIV_LAT = 4,
   parameter int unsigned CNT_W      = 32
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             cnt_clr_i,
   input  logic [4:0]       rs1_d_i,
   input  logic [4:0]       rs2_d_i,
   input  logic [4:0]       rs1_e_i,
   input  logic [4:0]       rs2_e_i,
   input  logic [4:0]       rd_e_i,
   input  logic [4:0]       rd_m_i,
   input  logic [4:0]       rd_w_i,
   input  logic [1:0]       result_src_e_i,
   input  logic             reg_write_m_i,
   input  logic             reg_write_w_i,
   input  logic             pc_src_e_i,
   input  logic             mul_div_e_i,
   output logic [1:0]       forward_ae_o,
   output logic [1:0]       forward_be_o,
   output logic             stall_f_o,
   output logic             stall_d_o,
   output logic             stall_e_o,
   output logic             flush_d_o,
   output logic             flush_e_o,
   output logic             flush_m_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] stall_count_o,
   output logic [CNT_W-1:0] flush_count_o
);

   localparam logic [CNT_W-1:0] CntMax = '1;

   logic             busy;
   logic             lw_stall;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   muldiv_hold_fsm #(
      .MULDIV_LAT(MULDIV_LAT)
   ) u_hold (
      .Clk     (Clk),
      .Reset   (Reset),
      .muldiv_i(mul_div_e_i),
      .busy_o  (busy)
   );

   assign forward_ae_o = fwd_sel(rs1_e_i, rd_m_i, rd_w_i, reg_write_m_i, reg_write_w_i);
   assign forward_be_o = fwd_sel(rs2_e_i, rd_m_i, rd_w_i, reg_write_m_i, reg_write_w_i);

   // A taken branch discards the younger instrs, so the redirect must not be held.
   assign lw_stall = (result_src_e_i == RES_LOAD) && (rd_e_i != 5'd0) &&
                     ((rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i)) && !pc_src_e_i && !busy;

   always_comb begin
      stall_f_o = 1'b0;
      stall_d_o = 1'b0;
      stall_e_o = 1'b0;
      flush_d_o = 1'b0;
      flush_e_o = 1'b0;
      flush_m_o = 1'b0;
      if (Reset) begin
         // all held at zero
      end else if (busy) begin
         stall_f_o = 1'b1;
         stall_d_o = 1'b1;
         stall_e_o = 1'b1;
         flush_m_o = 1'b1;
      end else begin
         stall_f_o = lw_stall;
         stall_d_o = lw_stall;
         flush_d_o = pc_src_e_i;
         flush_e_o = lw_stall || pc_src_e_i;
      end
   end

   assign busy_o = busy;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (cnt_clr_i) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if (stall_f_o && (stall_cnt_q != CntMax)) stall_cnt_d = stall_cnt_q + 1'b1;
         if ((flush_e_o || flush_m_o) && (flush_cnt_q != CntMax)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_count_o = stall_cnt_q;
   assign flush_count_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: each driven vector pushes its expected outputs,
// a monitor pops and compares once per cycle just before the rising edge.
module tb_hazard_unit;

   typedef struct packed {
      logic       reset;
      logic       cnt_clr;
      logic [4:0] rs1_d;
      logic [4:0] rs2_d;
      logic [4:0] rs1_e;
      logic [4:0] rs2_e;
      logic [4:0] rd_e;
      logic [4:0] rd_m;
      logic [4:0] rd_w;
      logic [1:0] res_src;
      logic       we_m;
      logic       we_w;
      logic       pc_src;
      logic       muldiv;
   } vec_t;

   typedef struct packed {
      logic [1:0] fwd_a;
      logic [1:0] fwd_b;
      logic       stall_f;
      logic       stall_d;
      logic       stall_e;
      logic       flush_d;
      logic       flush_e;
      logic       flush_m;
      logic       busy;
      logic [3:0] stall_cnt;
      logic [3:0] flush_cnt;
   } exp_t;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       cnt_clr = 1'b0;
   logic [4:0] rs1_d = '0, rs2_d = '0, rs1_e = '0, rs2_e = '0;
   logic [4:0] rd_e = '0, rd_m = '0, rd_w = '0;
   logic [1:0] res_src = '0;
   logic       we_m = 1'b0, we_w = 1'b0, pc_src = 1'b0, muldiv = 1'b0;
   logic [1:0] fwd_a, fwd_b;
   logic       stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, busy;
   logic [3:0] stall_cnt, flush_cnt;

   exp_t  exp_q[$];
   string name_q[$];
   int    checks = 0;
   int    errors = 0;
   logic [3:0] m_stall = '0;
   logic [3:0] m_flush = '0;

   always #5 Clk = ~Clk;

   hazard_unit #(
      .MULDIV_LAT(4),
      .CNT_W     (4)
   ) dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .cnt_clr_i     (cnt_clr),
      .rs1_d_i       (rs1_d),
      .rs2_d_i       (rs2_d),
      .rs1_e_i       (rs1_e),
      .rs2_e_i       (rs2_e),
      .rd_e_i        (rd_e),
      .rd_m_i        (rd_m),
      .rd_w_i        (rd_w),
      .result_src_e_i(res_src),
      .reg_write_m_i (we_m),
      .reg_write_w_i (we_w),
      .pc_src_e_i    (pc_src),
      .mul_div_e_i   (muldiv),
      .forward_ae_o  (fwd_a),
      .forward_be_o  (fwd_b),
      .stall_f_o     (stall_f),
      .stall_d_o     (stall_d),
      .stall_e_o     (stall_e),
      .flush_d_o     (flush_d),
      .flush_e_o     (flush_e),
      .flush_m_o     (flush_m),
      .busy_o        (busy),
      .stall_count_o (stall_cnt),
      .flush_count_o (flush_cnt)
   );

   function automatic vec_t idle_v();
      vec_t v;
      v = '0;
      return v;
   endfunction

   function automatic vec_t load_use_v();
      vec_t v;
      v = '0;
      v.res_src = 2'b01;
      v.rd_e    = 5'd7;
      v.rs2_d   = 5'd7;
      return v;
   endfunction

   function automatic exp_t quiet_e();
      exp_t e;
      e = '0;
      return e;
   endfunction

   function automatic exp_t lw_e();
      exp_t e;
      e = '0;
      e.stall_f = 1'b1;
      e.stall_d = 1'b1;
      e.flush_e = 1'b1;
      return e;
   endfunction

   function automatic exp_t busy_e();
      exp_t e;
      e = '0;
      e.stall_f = 1'b1;
      e.stall_d = 1'b1;
      e.stall_e = 1'b1;
      e.flush_m = 1'b1;
      e.busy    = 1'b1;
      return e;
   endfunction

   // Counter expectations come from a saturating model updated per driven cycle.
   task automatic apply(input vec_t v, input exp_t e, input string name);
      @(negedge Clk);
      Reset   = v.reset;
      cnt_clr = v.cnt_clr;
      rs1_d   = v.rs1_d;
      rs2_d   = v.rs2_d;
      rs1_e   = v.rs1_e;
      rs2_e   = v.rs2_e;
      rd_e    = v.rd_e;
      rd_m    = v.rd_m;
      rd_w    = v.rd_w;
      res_src = v.res_src;
      we_m    = v.we_m;
      we_w    = v.we_w;
      pc_src  = v.pc_src;
      muldiv  = v.muldiv;
      if (v.reset) begin
         m_stall = '0;
         m_flush = '0;
      end
      e.stall_cnt = m_stall;
      e.flush_cnt = m_flush;
      exp_q.push_back(e);
      name_q.push_back(name);
      if (v.reset || v.cnt_clr) begin
         m_stall = '0;
         m_flush = '0;
      end else begin
         if (e.stall_f && (m_stall != 4'hF)) m_stall = m_stall + 4'd1;
         if ((e.flush_e || e.flush_m) && (m_flush != 4'hF)) m_flush = m_flush + 4'd1;
      end
   endtask

   initial begin : monitor
      exp_t  e;
      exp_t  act;
      string n;
      forever begin
         @(negedge Clk);
         #4;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            act = '{fwd_a, fwd_b, stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, busy,
                    stall_cnt, flush_cnt};
            checks++;
            if (act !== e) begin
               errors++;
               $display("FAIL %s: got %h expected %h (fa fb sf sd se fd fe fm bz sc fc)",
                        n, act, e);
            end
         end
      end
   end

   initial begin : stimulus
      vec_t v;
      exp_t e;

      apply(idle_v(), quiet_e(), "reset0");
      v = load_use_v();
      v.reset  = 1'b1;
      v.muldiv = 1'b1;
      v.pc_src = 1'b1;
      apply(v, quiet_e(), "reset_forces_zero");

      // Forwarding priority
      v = idle_v();
      v.rd_m = 5'd5; v.we_m = 1'b1; v.rd_w = 5'd5; v.we_w = 1'b1; v.rs1_e = 5'd5; v.rs2_e = 5'd3;
      e = quiet_e(); e.fwd_a = 2'b10;
      apply(v, e, "fwd_mem_beats_wb");
      v.we_m = 1'b0;
      e.fwd_a = 2'b01;
      apply(v, e, "fwd_wb");
      v = idle_v();
      v.we_m = 1'b1; v.we_w = 1'b1;
      apply(v, quiet_e(), "fwd_rd_zero");
      v = idle_v();
      v.rs1_e = 5'd4; v.rd_m = 5'd4; v.we_m = 1'b1;
      v.rs2_e = 5'd9; v.rd_w = 5'd9; v.we_w = 1'b1;
      e = quiet_e(); e.fwd_a = 2'b10; e.fwd_b = 2'b01;
      apply(v, e, "fwd_a_mem_b_wb");

      // Load-use
      apply(load_use_v(), lw_e(), "load_use_stall");
      apply(idle_v(), quiet_e(), "after_load_use");
      v = load_use_v(); v.rd_e = 5'd0; v.rs2_d = 5'd0;
      apply(v, quiet_e(), "load_rd_zero");
      v = load_use_v(); v.res_src = 2'b00;
      apply(v, quiet_e(), "alu_no_stall");

      // Branch flush wins over load-use
      v = load_use_v(); v.pc_src = 1'b1;
      e = quiet_e(); e.flush_d = 1'b1; e.flush_e = 1'b1;
      apply(v, e, "load_use_plus_branch");
      v = idle_v(); v.pc_src = 1'b1;
      apply(v, e, "branch_only");

      // MUL/DIV hold, LAT=4: three busy cycles, released on fourth
      v = idle_v(); v.muldiv = 1'b1;
      apply(v, busy_e(), "muldiv_c1");
      v = load_use_v(); v.muldiv = 1'b1; v.pc_src = 1'b1;
      apply(v, busy_e(), "muldiv_c2_masks_lw_br");
      v = idle_v(); v.muldiv = 1'b1;
      apply(v, busy_e(), "muldiv_c3");
      apply(v, quiet_e(), "muldiv_release_no_retrigger");
      apply(idle_v(), quiet_e(), "muldiv_after");

      // Reset during HOLD with cnt=1
      v = idle_v(); v.muldiv = 1'b1;
      apply(v, busy_e(), "hold_a");
      apply(v, busy_e(), "hold_b");
      v.reset = 1'b1;
      apply(v, quiet_e(), "reset_mid_hold");
      v = idle_v(); v.muldiv = 1'b1;
      apply(v, busy_e(), "post_reset_idle_entry");
      apply(idle_v(), busy_e(), "post_reset_h1");
      apply(idle_v(), busy_e(), "post_reset_h2");
      apply(idle_v(), quiet_e(), "post_reset_release");

      // Saturation
      v = idle_v(); v.cnt_clr = 1'b1;
      apply(v, quiet_e(), "cnt_clr");
      for (int i = 0; i < 14; i++) apply(load_use_v(), lw_e(), "preload_stall");
      for (int i = 0; i < 3; i++) apply(load_use_v(), lw_e(), "saturate_stall");
      apply(idle_v(), quiet_e(), "saturated_hold");
      v = load_use_v(); v.cnt_clr = 1'b1;
      apply(v, lw_e(), "clr_with_stall");
      apply(idle_v(), quiet_e(), "after_clr");

      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge Clk);
      #6;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
